// File: rtl/jmbl_chk_pkg.sv
// Shared types and defaults for the jmbl trace checker.
// Holds the tracking-state enum, the error-class codes and the default recurrence constants.
package jmbl_chk_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_INIT = 2'd1;
    localparam logic [1:0] ERR_STEP = 2'd2;
    localparam logic [1:0] ERR_INV  = 2'd3;

    localparam int DEF_LIMIT  = 200;
    localparam int DEF_X_INIT = 1;
    localparam int DEF_Y_INIT = 0;

endpackage

// File: rtl/jmbl_step_model.sv
// Combinational replay of one step of the jmbl recurrence.
// Produces the expected next (x, y) and the INIT / STEP / INV check bits for the incoming sample.
module jmbl_step_model
    import jmbl_chk_pkg::*;
#(
    parameter int W      = 11,
    parameter int LIMIT  = DEF_LIMIT,
    parameter int X_INIT = DEF_X_INIT,
    parameter int Y_INIT = DEF_Y_INIT
) (
    input  logic [1:0]   state,
    input  logic [W-1:0] prev_x,
    input  logic [W-1:0] prev_y,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic [W-1:0] exp_x,
    output logic [W-1:0] exp_y,
    output logic         init_bad,
    output logic         step_bad,
    output logic         inv_bad
);

    localparam logic [W-1:0] LIMIT_W  = W'(LIMIT);
    localparam logic [W-1:0] X_INIT_W = W'(X_INIT);
    localparam logic [W-1:0] Y_INIT_W = W'(Y_INIT);

    logic mismatch;

    always_comb begin
        exp_x = X_INIT_W;
        exp_y = Y_INIT_W;
        case (state)
            RUN: begin
                // x wraps modulo 2^W, matching the upstream accumulator width
                exp_x = prev_x + prev_y;
                exp_y = prev_y + W'(1);
            end
            HOLD: begin
                exp_x = prev_x;
                exp_y = prev_y;
            end
            default: begin
                exp_x = X_INIT_W;
                exp_y = Y_INIT_W;
            end
        endcase
    end

    assign mismatch = (in_x != exp_x) || (in_y != exp_y);
    assign init_bad = (state == EMPTY) && mismatch;
    assign step_bad = (state != EMPTY) && mismatch;
    assign inv_bad  = (in_y >= LIMIT_W) && (in_x < in_y);

endmodule

// File: rtl/jmbl_trace_checker.sv
// Monitor that replays the jmbl accumulator recurrence on the upstream (x, y) stream.
// Flags the first divergence, counts violations and samples, and snapshots the first failing sample.
module jmbl_trace_checker
    import jmbl_chk_pkg::*;
#(
    parameter int W      = 11,
    parameter int LIMIT  = DEF_LIMIT,
    parameter int X_INIT = DEF_X_INIT,
    parameter int Y_INIT = DEF_Y_INIT,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    output logic             converged,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [15:0]      sample_cnt,
    output logic [W-1:0]     fail_x,
    output logic [W-1:0]     fail_y,
    output logic [15:0]      fail_idx,
    output logic [1:0]       dbg_state
);

    // Handshake: a sample is consumed on every rising edge where in_valid=1, clr=0 and in_rst=0;
    // there is no ready, the checker never stalls and accepts one sample per cycle.

    localparam logic [W-1:0]     LIMIT_W = W'(LIMIT);
    localparam logic [CNT_W-1:0] VIOL_MAX = {CNT_W{1'b1}};

    state_t       state;
    logic [W-1:0] prev_x;
    logic [W-1:0] prev_y;
    logic [W-1:0] exp_x;
    logic [W-1:0] exp_y;
    logic         init_bad;
    logic         step_bad;
    logic         inv_bad;
    logic         any_bad;
    logic [1:0]   code_now;

    jmbl_step_model #(
        .W      (W),
        .LIMIT  (LIMIT),
        .X_INIT (X_INIT),
        .Y_INIT (Y_INIT)
    ) u_step (
        .state    (state),
        .prev_x   (prev_x),
        .prev_y   (prev_y),
        .in_x     (in_x),
        .in_y     (in_y),
        .exp_x    (exp_x),
        .exp_y    (exp_y),
        .init_bad (init_bad),
        .step_bad (step_bad),
        .inv_bad  (inv_bad)
    );

    assign any_bad  = init_bad || step_bad || inv_bad;
    assign code_now = inv_bad  ? ERR_INV  :
                      step_bad ? ERR_STEP :
                      init_bad ? ERR_INIT : ERR_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            prev_x     <= '0;
            prev_y     <= '0;
            fail       <= 1'b0;
            err_code   <= ERR_NONE;
            viol_cnt   <= '0;
            sample_cnt <= '0;
            fail_x     <= '0;
            fail_y     <= '0;
            fail_idx   <= '0;
        end else if (clr) begin
            state      <= EMPTY;
            prev_x     <= '0;
            prev_y     <= '0;
            fail       <= 1'b0;
            err_code   <= ERR_NONE;
            viol_cnt   <= '0;
            sample_cnt <= '0;
            fail_x     <= '0;
            fail_y     <= '0;
            fail_idx   <= '0;
        end else if (in_rst) begin
            // Upstream restarted: only tracking resets, history is kept for the harness
            state <= EMPTY;
        end else if (in_valid) begin
            prev_x <= in_x;
            prev_y <= in_y;
            state  <= (in_y >= LIMIT_W) ? HOLD : RUN;
            if (any_bad && (viol_cnt != VIOL_MAX)) begin
                viol_cnt <= viol_cnt + CNT_W'(1);
            end
            if (any_bad && !fail) begin
                fail     <= 1'b1;
                err_code <= code_now;
                fail_x   <= in_x;
                fail_y   <= in_y;
                fail_idx <= sample_cnt;
            end
            if (sample_cnt != 16'hFFFF) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
        end
    end

    assign converged = (state == HOLD);
    assign dbg_state = state;

endmodule

// File: tb/tb_jmbl_trace_checker.sv
// Self-checking bench for jmbl_trace_checker: directed scenarios plus a randomized stream,
// all compared against a sample-level reference model of the recurrence rules.
`timescale 1ns/1ps
module tb_jmbl_trace_checker;
    import jmbl_chk_pkg::*;

    localparam int W     = 11;
    localparam int WMOD  = 2048;
    localparam int LIM   = 200;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_rst;
    logic             in_valid;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic             converged;
    logic             fail;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] viol_cnt;
    logic [15:0]      sample_cnt;
    logic [W-1:0]     fail_x;
    logic [W-1:0]     fail_y;
    logic [15:0]      fail_idx;
    logic [1:0]       dbg_state;

    int checks;
    int failures;

    // reference model: last sample kept as plain integers
    bit m_have;
    int m_px, m_py;
    bit m_fail;
    int m_code, m_viol, m_cnt, m_fx, m_fy, m_fidx;

    jmbl_trace_checker #(
        .W     (W),
        .LIMIT (LIM),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_rst     (in_rst),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .converged  (converged),
        .fail       (fail),
        .err_code   (err_code),
        .viol_cnt   (viol_cnt),
        .sample_cnt (sample_cnt),
        .fail_x     (fail_x),
        .fail_y     (fail_y),
        .fail_idx   (fail_idx),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_px = 0; m_py = 0;
        m_fail = 0; m_code = 0; m_viol = 0; m_cnt = 0;
        m_fx = 0; m_fy = 0; m_fidx = 0;
    endtask

    task automatic model_step(input bit v, input bit r, input bit c, input int x, input int y);
        bit b_init, b_step, b_inv;
        int code;
        if (c) begin
            model_reset();
        end else if (r) begin
            m_have = 0;
        end else if (v) begin
            b_init = !m_have && (x != 1 || y != 0);
            if (!m_have)        b_step = 0;
            else if (m_py < LIM) b_step = (x != (m_px + m_py) % WMOD) || (y != m_py + 1);
            else                b_step = (x != m_px) || (y != m_py);
            b_inv = (y >= LIM) && (x < y);
            code = b_inv ? 3 : b_step ? 2 : b_init ? 1 : 0;
            if (code != 0) begin
                if (m_viol < 255) m_viol++;
                if (!m_fail) begin
                    m_fail = 1; m_code = code; m_fx = x; m_fy = y; m_fidx = m_cnt;
                end
            end
            if (m_cnt < 65535) m_cnt++;
            m_px = x; m_py = y; m_have = 1;
        end
    endtask

    task automatic compare_all();
        int exp_state;
        exp_state = !m_have ? int'(EMPTY) : (m_py >= LIM) ? int'(HOLD) : int'(RUN);
        check("converged",  converged,  (m_have && m_py >= LIM) ? 1 : 0);
        check("state",      dbg_state,  exp_state);
        check("fail",       fail,       m_fail);
        check("err_code",   err_code,   m_code);
        check("viol_cnt",   viol_cnt,   m_viol);
        check("sample_cnt", sample_cnt, m_cnt);
        check("fail_x",     fail_x,     m_fx);
        check("fail_y",     fail_y,     m_fy);
        check("fail_idx",   fail_idx,   m_fidx);
    endtask

    // driver: called at a negedge, drives for one edge, returns at the next negedge after checking
    task automatic drive(input bit v, input bit r, input bit c, input int x, input int y);
        in_valid = v; in_rst = r; clr = c;
        in_x = W'(x); in_y = W'(y);
        @(posedge clk);
        model_step(v, r, c, x, y);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input int x, input int y);
        drive(1'b1, 1'b0, 1'b0, x, y);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // next value a conforming upstream would produce, from the model's last sample
    task automatic good_next(output int x, output int y);
        if (!m_have)         begin x = 1;                     y = 0;        end
        else if (m_py < LIM) begin x = (m_px + m_py) % WMOD; y = m_py + 1; end
        else                 begin x = m_px;                  y = m_py;     end
    endtask

    task automatic do_reset();
        in_valid = 0; in_rst = 0; clr = 0; in_x = '0; in_y = '0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic run_good(input int n);
        int x, y;
        for (int i = 0; i < n; i++) begin
            good_next(x, y);
            send(x, y);
        end
    endtask

    initial begin
        int x, y, sel;
        checks = 0;
        failures = 0;
        rst_n = 0;
        do_reset();
        compare_all();
        check("rst_cnt", sample_cnt, 0);

        // nominal run, closed-form expectation for sample k is x = 1 + k(k-1)/2 mod 2^W
        for (int k = 0; k < 220; k++) begin
            x = (1 + (k * (k - 1)) / 2) % WMOD;
            y = k;
            if (k > LIM) begin x = 1469; y = LIM; end
            if (k == LIM) check("s200_x", x, 1469);
            send(x, y);
            if (k == LIM - 1) check("conv_pre200", converged, 0);
            if (k == LIM)     check("conv_at200", converged, 1);
        end
        check("nom_fail", fail, 0);
        check("nom_cnt", sample_cnt, 220);

        // step error on sample 5
        do_reset();
        run_good(5);
        send(0, 5);
        check("step_code", err_code, 2);
        check("step_idx", fail_idx, 5);
        check("step_fx", fail_x, 0);
        send(11, 6);
        check("step_viol2", viol_cnt, 2);

        // init error, tracking follows the received sample
        do_reset();
        send(2, 0);
        check("init_code", err_code, 1);
        check("init_idx", fail_idx, 0);
        send(2, 1);
        check("init_follow", viol_cnt, 1);

        // invariant error while holding
        do_reset();
        run_good(205);
        send(100, 250);
        check("inv_code", err_code, 3);

        // resync via in_rst
        do_reset();
        run_good(10);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        check("resync_empty", dbg_state, int'(EMPTY));
        send(1, 0);
        check("resync_run", dbg_state, int'(RUN));
        check("resync_viol", viol_cnt, 0);
        check("resync_cnt", sample_cnt, 11);

        // asynchronous reset mid-run
        run_good(3);
        send(7, 7);
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        check("async_fail", fail, 0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // clr with a bad sample present
        run_good(4);
        send(9, 9);
        drive(1'b1, 1'b0, 1'b1, 5, 300);
        check("clr_viol", viol_cnt, 0);
        check("clr_cnt", sample_cnt, 0);

        // violation counter saturation
        for (int i = 0; i < 300; i++) send(0, 250);
        check("sat_viol", viol_cnt, 255);

        // randomized stream, back-to-back with occasional disturbances
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 82) begin
                good_next(x, y);
                send(x, y);
            end else if (sel < 88) begin
                send($urandom_range(0, WMOD - 1), $urandom_range(0, 300));
            end else if (sel < 92) begin
                drive(1'b1, 1'b1, 1'b0, $urandom_range(0, WMOD - 1), $urandom_range(0, 300));
            end else if (sel < 99) begin
                idle();
            end else begin
                drive(1'b1, 1'b0, 1'b1, $urandom_range(0, WMOD - 1), $urandom_range(0, 300));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jmbl_trace_checker.md
# jmbl_trace_checker

Downstream monitor for the jmbl accumulator stage. It consumes the stage's (x, y) output stream and replays the recurrence independently: each cycle where y < LIMIT, x advances by y and y advances by 1; once y reaches LIMIT, both hold. It flags the first divergence from that recurrence or from the invariant (y < LIMIT) || (x >= y), and reports convergence, counters and a captured failure snapshot to the property-mining harness.

## Interface
- W, 11: data width of x and y.
- LIMIT, 200: y threshold at which the upstream stage holds.
- X_INIT, 1: x value expected on the first sample.
- Y_INIT, 0: y value expected on the first sample.
- CNT_W, 8: violation counter width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, equivalent to reset.
- in_rst  in  1  upstream reset seen; restart tracking.
- in_valid  in  1  a sample is present this cycle.
- in_x  in  W  upstream x.
- in_y  in  W  upstream y.
- converged  out  1  tracking reached the hold region (y >= LIMIT).
- fail  out  1  sticky; at least one violation seen.
- err_code  out  2  error class of the first violation: 0 none, 1 INIT, 2 STEP, 3 INV.
- viol_cnt  out  CNT_W  count of violating samples; saturates.
- sample_cnt  out  16  count of accepted samples; saturates at 65535.
- fail_x, fail_y  out  W  x and y of the first violating sample.
- fail_idx  out  16  sample_cnt value at the first violation.

## Operation
- **States**
  - EMPTY: no previous sample.
  - RUN: previous y < LIMIT.
  - HOLD: previous y >= LIMIT.
  - Registers prev_x and prev_y hold the last accepted sample.
- **Accepted sample:** in_valid=1, with clr=0 and in_rst=0.
- **Checks on each accepted sample**
  - INIT (EMPTY only): fails if in_x != X_INIT or in_y != Y_INIT.
  - STEP, from RUN: fails unless in_y == prev_y+1 and in_x == (prev_x+prev_y) mod 2^W.
  - STEP, from HOLD: fails unless in_x == prev_x and in_y == prev_y.
  - INV (all states): fails if in_y >= LIMIT and in_x < in_y. All comparisons are unsigned.
  - Code priority when several checks fail on one sample: INV over STEP over INIT.
- **Update on each accepted sample**
  - prev is loaded with the sample.
  - Next state is HOLD if in_y >= LIMIT, else RUN. Tracking continues after a failure.
  - Any failing check increments viol_cnt by exactly 1, saturating at 2^CNT_W-1.
  - On the first failure: fail is set, and err_code, fail_x, fail_y and fail_idx are captured. They are frozen until reset or clr.
  - sample_cnt increments after the check. fail_idx therefore equals the 0-based index of the violating sample.
- **in_valid=0:** no change.
- **in_rst=1:** state goes to EMPTY and the sample is ignored. All flags, counters and captures are kept.
- **clr=1:** same effect as reset. It takes precedence over in_rst and in_valid.
- **converged:** equals (state == HOLD).
- **Reset values:** state EMPTY, and every output 0.

## Timing
- All outputs are registered. A sample accepted at edge N is reflected in the outputs after edge N.
- Checks are single-cycle; there are no stall paths. A back-to-back sample every cycle is supported.
- rst_n assertion clears everything immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- Reset mid-run: the next accepted sample is checked as INIT.

## Structure
- Shared package jmbl_chk_pkg holds:
  - the state enum (EMPTY, RUN, HOLD);
  - the err_code constants (ERR_NONE, ERR_INIT, ERR_STEP, ERR_INV);
  - the default LIMIT, X_INIT and Y_INIT values.
- Sub-module jmbl_step_model: a combinational block. Given prev_x, prev_y and the state, it produces the expected x and y and the three check bits.
- The top level holds the FSM, counters and capture registers.

## Test plan
- **Nominal run:** reset, then 220 samples from a conforming upstream (x=1, y=0).
  - Sample 200 is x=1469, y=200.
  - converged rises after sample 200.
  - fail stays 0, and sample_cnt ends at 220.
- **Step error:** corrupt sample 5 to x=0 (expected x=11, y=5).
  - fail=1, err_code=2, fail_x=0, fail_y=5, fail_idx=5, viol_cnt=1.
  - Sample 6 is then a STEP violation against prev_x=0, so viol_cnt=2.
- **Init error:** first sample x=2, y=0.
  - err_code=1, fail_idx=0.
  - Tracking proceeds from the sample as received.
- **Invariant error in HOLD:** feed x=100, y=250 while in HOLD.
  - err_code=3, because INV outranks STEP.
- **Resync:** pulse in_rst mid-run, then send x=1, y=0.
  - No violation is raised.
  - State goes EMPTY then RUN.
  - sample_cnt is retained.
- **Reset and clear:** assert rst_n low asynchronously mid-run; separately assert clr together with in_valid and a bad sample.
  - rst_n: all outputs read 0 before the next clock edge.
  - clr: the sample is dropped, and all outputs are 0 after the edge.
  - Saturation: 300 consecutive bad samples leave viol_cnt at 255.
